// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops bytes from the TX FIFO read side and frames them
// onto tx. Define UART_TX_PARITY_EN to add a parity bit after the data bits.
module uart_tx_fifo_drain #(
  parameter int data_bits  = 8,
  parameter int sb_ticks   = 16,
  parameter int parity_odd = 0
) (
  input  logic                 clk,
  input  logic                 Reset_n,
  input  logic                 s_tick,
  input  logic                 fifo_empty,
  input  logic [data_bits-1:0] fifo_data,
  output logic                 fifo_rd,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  if (data_bits < 5 || data_bits > 8) begin : g_bad_data_bits
    $error("data_bits must be in 5..8");
  end
  if (sb_ticks != 16 && sb_ticks != 24 && sb_ticks != 32) begin : g_bad_sb_ticks
    $error("sb_ticks must be 16, 24 or 32");
  end
  if (parity_odd != 0 && parity_odd != 1) begin : g_bad_parity_odd
    $error("parity_odd must be 0 or 1");
  end

  localparam logic [4:0] SB_LAST = 5'(sb_ticks - 1);
  localparam logic [2:0] N_LAST  = 3'(data_bits - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [4:0]           s_q, s_d;
  logic [2:0]           n_q, n_d;
  logic [data_bits-1:0] b_q, b_d;
  logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_INV = (parity_odd != 0);
  logic                 par_q, par_d;
`endif

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    fifo_rd      = 1'b0;
    tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      IDLE: begin
        // Reset gates the pop so a non-empty FIFO is never drained while held.
        if (!fifo_empty && Reset_n) begin
          fifo_rd = 1'b1;
          b_d     = fifo_data;
          s_d     = '0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = (^fifo_data) ^ PAR_INV;
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == 5'd15) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == 5'd15) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == 5'd15) begin
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_q == SB_LAST) begin
            tx_done_tick = 1'b1;
            state_d      = IDLE;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is decoded from the next state so the pin is a clean flop output.
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);

endmodule
